// File: rtl/branch_sequencer.sv
// Micro-sequencer for the RISC datapath: fetch with memory-ready timeout, then
// branch / jump-register / jump-and-link / nop / halt execution as Moore strobes.
module branch_sequencer #(
    parameter int                    DATA_W   = 32,
    parameter int                    OPCODE_W = 5,
    parameter logic [OPCODE_W-1:0]   BR_OP    = 5'b10010,
    parameter logic [OPCODE_W-1:0]   JR_OP    = 5'b10100,
    parameter logic [OPCODE_W-1:0]   JAL_OP   = 5'b10011,
    parameter logic [OPCODE_W-1:0]   NOP_OP   = 5'b11010,
    parameter logic [OPCODE_W-1:0]   HALT_OP  = 5'b11011,
    parameter int                    TIMEOUT  = 16,
    parameter int                    COUNT_W  = 16
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Run,
    input  logic [DATA_W-1:0]  IR,
    input  logic               CON_FF,
    input  logic               Mem_ready,
    output logic               PCout,
    output logic               MARin,
    output logic               IncPC,
    output logic               PCin,
    output logic               Read,
    output logic               MDRin,
    output logic               MDRout,
    output logic               IRin,
    output logic               Gra,
    output logic               Grb,
    output logic               Rout,
    output logic               Rin,
    output logic               CONin,
    output logic               Yin,
    output logic               Cout,
    output logic               Zin,
    output logic               Zlowout,
    output logic               Busy,
    output logic               Halted,
    output logic               Mem_timeout,
    output logic               Illegal,
    output logic [COUNT_W-1:0] Instr_count
);

    localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH0, S_FETCH1, S_FETCH2, S_DECODE,
        S_BR3, S_BR4, S_BR5, S_BR6, S_JR3, S_JAL3, S_JAL4,
        S_HALT, S_ERROR
    } state_t;

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                take_q, take_d;
    logic                illegal_q, illegal_d;
    logic [COUNT_W-1:0]  count_q, count_d;
    logic                retire;

    logic [OPCODE_W-1:0] opcode;
    logic                unused_ir_bits;

    assign opcode         = IR[DATA_W-1 -: OPCODE_W];
    assign unused_ir_bits = ^IR[DATA_W-OPCODE_W-1:0];

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q   <= S_IDLE;
            wait_q    <= '0;
            take_q    <= 1'b0;
            illegal_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            take_q    <= take_d;
            illegal_q <= illegal_d;
            count_q   <= count_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        take_d    = take_q;
        illegal_d = illegal_q;
        count_d   = count_q;
        retire    = 1'b0;
        case (state_q)
            S_IDLE:   if (Run) state_d = S_FETCH0;
            S_FETCH0: begin
                state_d = S_FETCH1;
                wait_d  = '0;
            end
            S_FETCH1: begin
                // The compare value is the count of waits already spent, so the
                // TIMEOUT-th consecutive not-ready cycle is the one that errors out.
                if (Mem_ready)                        state_d = S_FETCH2;
                else if (wait_q == WAIT_W'(TIMEOUT-1)) state_d = S_ERROR;
                else                                  wait_d  = wait_q + WAIT_W'(1);
            end
            S_FETCH2: state_d = S_DECODE;
            S_DECODE: begin
                if (opcode == BR_OP)        state_d = S_BR3;
                else if (opcode == JR_OP)   state_d = S_JR3;
                else if (opcode == JAL_OP)  state_d = S_JAL3;
                else if (opcode == HALT_OP) begin
                    state_d = S_HALT;
                    count_d = count_q + COUNT_W'(1);
                end else if (opcode == NOP_OP) begin
                    retire = 1'b1;
                end else begin
                    illegal_d = 1'b1;
                    retire    = 1'b1;
                end
            end
            S_BR3:    state_d = S_BR4;
            S_BR4:    state_d = S_BR5;
            S_BR5: begin
                state_d = S_BR6;
                take_d  = CON_FF;
            end
            S_BR6:    retire  = 1'b1;
            S_JR3:    retire  = 1'b1;
            S_JAL3:   state_d = S_JAL4;
            S_JAL4:   retire  = 1'b1;
            S_HALT:   state_d = S_HALT;
            S_ERROR:  state_d = S_ERROR;
            default:  state_d = S_IDLE;
        endcase
        if (retire) begin
            count_d = count_q + COUNT_W'(1);
            state_d = Run ? S_FETCH0 : S_IDLE;
        end
    end

    always_comb begin
        PCout   = 1'b0;
        MARin   = 1'b0;
        IncPC   = 1'b0;
        PCin    = 1'b0;
        Read    = 1'b0;
        MDRin   = 1'b0;
        MDRout  = 1'b0;
        IRin    = 1'b0;
        Gra     = 1'b0;
        Grb     = 1'b0;
        Rout    = 1'b0;
        Rin     = 1'b0;
        CONin   = 1'b0;
        Yin     = 1'b0;
        Cout    = 1'b0;
        Zin     = 1'b0;
        Zlowout = 1'b0;
        case (state_q)
            S_FETCH0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                PCin  = 1'b1;
            end
            S_FETCH1: begin
                Read  = 1'b1;
                MDRin = 1'b1;
            end
            S_FETCH2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_BR3: begin
                Gra   = 1'b1;
                Rout  = 1'b1;
                CONin = 1'b1;
            end
            S_BR4: begin
                PCout = 1'b1;
                Yin   = 1'b1;
            end
            S_BR5: begin
                Cout = 1'b1;
                Zin  = 1'b1;
            end
            S_BR6: begin
                Zlowout = take_q;
                PCin    = take_q;
            end
            S_JR3, S_JAL4: begin
                Gra  = 1'b1;
                Rout = 1'b1;
                PCin = 1'b1;
            end
            S_JAL3: begin
                PCout = 1'b1;
                Grb   = 1'b1;
                Rin   = 1'b1;
            end
            default: ;
        endcase
    end

    assign Busy        = (state_q != S_IDLE) && (state_q != S_HALT) && (state_q != S_ERROR);
    assign Halted      = (state_q == S_HALT);
    assign Mem_timeout = (state_q == S_ERROR);
    assign Illegal     = illegal_q;
    assign Instr_count = count_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// Randomised and directed bench for branch_sequencer, checked every cycle against
// an instruction-level model built from per-opcode micro-step tables.
module tb_branch_sequencer;

    localparam int TIMEOUT = 16;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_JAL  = 5'b10011;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;
    localparam logic [4:0] OP_BAD  = 5'b11111;

    localparam logic [16:0] M_PCOUT = 17'h10000, M_MARIN = 17'h08000, M_INCPC = 17'h04000,
                            M_PCIN  = 17'h02000, M_READ  = 17'h01000, M_MDRIN = 17'h00800,
                            M_MDROUT= 17'h00400, M_IRIN  = 17'h00200, M_GRA   = 17'h00100,
                            M_GRB   = 17'h00080, M_ROUT  = 17'h00040, M_RIN   = 17'h00020,
                            M_CONIN = 17'h00010, M_YIN   = 17'h00008, M_COUT  = 17'h00004,
                            M_ZIN   = 17'h00002, M_ZLOW  = 17'h00001;

    localparam int MD_IDLE = 0, MD_RUN = 1, MD_HALT = 2, MD_ERR = 3;
    localparam int K_NOP = 0, K_JR = 1, K_JAL = 2, K_BR = 3;

    logic        Clock = 1'b0;
    logic        Reset, Run, CON_FF, Mem_ready;
    logic [31:0] IR;
    logic PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin;
    logic Gra, Grb, Rout, Rin, CONin, Yin, Cout, Zin, Zlowout;
    logic Busy, Halted, Mem_timeout, Illegal;
    logic [15:0] Instr_count;
    logic [16:0] strobes;

    int checks = 0;
    int errors = 0;

    always #5 Clock = ~Clock;

    branch_sequencer dut (
        .Clock(Clock), .Reset(Reset), .Run(Run), .IR(IR), .CON_FF(CON_FF), .Mem_ready(Mem_ready),
        .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .PCin(PCin), .Read(Read), .MDRin(MDRin),
        .MDRout(MDRout), .IRin(IRin), .Gra(Gra), .Grb(Grb), .Rout(Rout), .Rin(Rin),
        .CONin(CONin), .Yin(Yin), .Cout(Cout), .Zin(Zin), .Zlowout(Zlowout),
        .Busy(Busy), .Halted(Halted), .Mem_timeout(Mem_timeout), .Illegal(Illegal),
        .Instr_count(Instr_count)
    );

    assign strobes = {PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin,
                      Gra, Grb, Rout, Rin, CONin, Yin, Cout, Zin, Zlowout};

    // ---------------- behavioural model ----------------
    bit          model_valid = 0;
    int          m_mode, m_step, m_kind, m_waits;
    bit          m_take, m_illegal;
    logic [15:0] m_count;

    function automatic int kind_of(logic [4:0] op);
        if (op == OP_BR)  return K_BR;
        if (op == OP_JR)  return K_JR;
        if (op == OP_JAL) return K_JAL;
        return K_NOP;
    endfunction

    // total micro-steps per instruction, fetch + decode included
    function automatic int ilen(int kind);
        case (kind)
            K_JR:    return 5;
            K_JAL:   return 6;
            K_BR:    return 8;
            default: return 4;
        endcase
    endfunction

    function automatic logic [16:0] exp_strobes(int mode, int kind, int step, bit take);
        logic [16:0] fetch_tbl [4];
        logic [16:0] br_tbl [4];
        if (mode != MD_RUN) return '0;
        fetch_tbl[0] = M_PCOUT | M_MARIN | M_INCPC | M_PCIN;
        fetch_tbl[1] = M_READ | M_MDRIN;
        fetch_tbl[2] = M_MDROUT | M_IRIN;
        fetch_tbl[3] = '0;
        if (step < 4) return fetch_tbl[step];
        br_tbl[0] = M_GRA | M_ROUT | M_CONIN;
        br_tbl[1] = M_PCOUT | M_YIN;
        br_tbl[2] = M_COUT | M_ZIN;
        br_tbl[3] = take ? (M_ZLOW | M_PCIN) : 17'h0;
        case (kind)
            K_BR:    return br_tbl[step-4];
            K_JR:    return M_GRA | M_ROUT | M_PCIN;
            K_JAL:   return (step == 4) ? (M_PCOUT | M_GRB | M_RIN) : (M_GRA | M_ROUT | M_PCIN);
            default: return '0;
        endcase
    endfunction

    task automatic model_retire();
        m_count = m_count + 16'd1;
        if (Run) m_step = 0;
        else     m_mode = MD_IDLE;
    endtask

    always @(posedge Clock) begin
        if (Reset === 1'b0) begin
            model_valid = 1;
            m_mode = MD_IDLE; m_step = 0; m_kind = K_NOP; m_waits = 0;
            m_take = 0; m_illegal = 0; m_count = '0;
        end else if (model_valid) begin
            case (m_mode)
                MD_IDLE: if (Run) begin m_mode = MD_RUN; m_step = 0; end
                MD_RUN: begin
                    if (m_step == 1) begin
                        if (Mem_ready)                  m_step = 2;
                        else if (m_waits == TIMEOUT-1)  m_mode = MD_ERR;
                        else                            m_waits++;
                    end else if (m_step == 3) begin
                        if (IR[31:27] == OP_HALT) begin
                            m_count = m_count + 16'd1;
                            m_mode  = MD_HALT;
                        end else begin
                            m_kind = kind_of(IR[31:27]);
                            if (m_kind == K_NOP && IR[31:27] != OP_NOP) m_illegal = 1;
                            m_step = 4;
                            if (ilen(m_kind) == 4) model_retire();
                        end
                    end else begin
                        if (m_kind == K_BR && m_step == 6) m_take = CON_FF;
                        m_step++;
                        if (m_step == 1) m_waits = 0;
                        if (m_step > 3 && m_step == ilen(m_kind)) model_retire();
                    end
                end
                default: ;
            endcase
        end
    end

    always @(negedge Clock) begin
        if (model_valid) begin
            logic [16:0] es;
            logic [3:0]  est, ast;
            es  = exp_strobes(m_mode, m_kind, m_step, m_take);
            est = {m_mode == MD_RUN, m_mode == MD_HALT, m_mode == MD_ERR, m_illegal};
            ast = {Busy, Halted, Mem_timeout, Illegal};
            checks += 3;
            if (strobes !== es) begin
                errors++;
                $display("FAIL strobes t=%0t actual=%h required=%h", $time, strobes, es);
            end
            if (ast !== est) begin
                errors++;
                $display("FAIL status(busy,halt,tmo,ill) t=%0t actual=%b required=%b", $time, ast, est);
            end
            if (Instr_count !== m_count) begin
                errors++;
                $display("FAIL instr_count t=%0t actual=%0d required=%0d", $time, Instr_count, m_count);
            end
        end
    end

    // ---------------- directed stimulus with literal expectations ----------------
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic do_reset();
        Reset = 1'b0; Run = 1'b0; Mem_ready = 1'b0; CON_FF = 1'b0;
        tick();
        Reset = 1'b1;
    endtask

    // Starts one instruction from IDLE; cycles excludes the IDLE->FETCH0 edge.
    task automatic run_instr(input logic [4:0] op, input bit con, input int mr_delay,
                             output int cycles, output int reads, output bit zl8);
        logic [15:0] start;
        IR = {op, 27'($urandom)};
        CON_FF = con; Run = 1'b1; Mem_ready = 1'b0;
        start = Instr_count; cycles = -1; reads = 0; zl8 = 0;
        for (int i = 1; i <= 60; i++) begin
            tick();
            reads += int'(Read);
            if (i == 8) begin
                zl8 = Zlowout & PCin;
                CON_FF = ~con;
            end
            if (Instr_count != start || Halted || Mem_timeout) begin
                cycles = i - 1;
                break;
            end
            if (i == 1) Run = 1'b0;
            if (i >= 2 + mr_delay) Mem_ready = 1'b1;
        end
        $display("instr op=%b con=%0d mr_delay=%0d cycles=%0d reads=%0d count=%0d",
                 op, con, mr_delay, cycles, reads, Instr_count);
    endtask

    initial begin
        int cyc, rd;
        bit zl;
        logic [4:0] seq_ops [5];
        int seq_cyc [5];
        Reset = 1'b0; Run = 1'b0; IR = '0; CON_FF = 1'b0; Mem_ready = 1'b0;
        tick(); tick();
        Reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle_strobes", 32'(strobes), 32'h0);
            check("idle_busy", 32'(Busy), 32'h0);
        end
        check("idle_count", 32'(Instr_count), 32'h0);

        run_instr(OP_BR, 1'b1, 0, cyc, rd, zl);
        check("br_taken_cycles", cyc, 8);
        check("br_taken_zlow_pcin", 32'(zl), 1);
        check("br_taken_count", 32'(Instr_count), 1);

        do_reset();
        run_instr(OP_BR, 1'b0, 0, cyc, rd, zl);
        check("br_not_cycles", cyc, 8);
        check("br_not_zlow_pcin", 32'(zl), 0);
        check("br_not_count", 32'(Instr_count), 1);

        run_instr(OP_NOP, 1'b0, 3, cyc, rd, zl);
        check("wait3_cycles", cyc, 7);
        check("wait3_fetch1_len", rd, 4);

        run_instr(OP_NOP, 1'b0, 1000, cyc, rd, zl);
        check("timeout_flag", 32'(Mem_timeout), 1);
        check("timeout_busy", 32'(Busy), 0);
        check("timeout_fetch1_len", rd, 16);

        do_reset();
        seq_ops = '{OP_JAL, OP_JR, OP_NOP, OP_BAD, OP_HALT};
        seq_cyc = '{6, 5, 4, 4, 4};
        for (int k = 0; k < 5; k++) begin
            run_instr(seq_ops[k], 1'b0, 0, cyc, rd, zl);
            check("seq_cycles", cyc, seq_cyc[k]);
            check("seq_illegal", 32'(Illegal), (k >= 3) ? 1 : 0);
        end
        check("seq_halted", 32'(Halted), 1);
        check("seq_count", 32'(Instr_count), 5);

        do_reset();
        run_instr(OP_NOP, 1'b0, 0, cyc, rd, zl);
        IR = {OP_BR, 27'd0}; CON_FF = 1'b1; Run = 1'b1; Mem_ready = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            Run = 1'b0;
        end
        check("br4_strobes", 32'(strobes), 32'(M_PCOUT | M_YIN));
        Reset = 1'b0;
        tick();
        check("midreset_strobes", 32'(strobes), 0);
        check("midreset_status", 32'({Busy, Halted, Mem_timeout, Illegal}), 0);
        check("midreset_count", 32'(Instr_count), 0);
        Reset = 1'b1;

        // ---------------- randomised phase ----------------
        for (int n = 0; n < 4000; n++) begin
            int mr_pct;
            int pick;
            mr_pct = ((n / 250) % 4 == 3) ? 5 : 75;
            if (Halted || Mem_timeout) Reset = ($urandom_range(0, 7) != 0);
            else                       Reset = ($urandom_range(0, 299) != 0);
            Run       = ($urandom_range(0, 3) != 0);
            CON_FF    = $urandom_range(0, 1) == 1;
            Mem_ready = ($urandom_range(0, 99) < mr_pct);
            pick = $urandom_range(0, 15);
            case (pick)
                0, 1, 2: IR = {OP_BR,  27'($urandom)};
                3, 4:    IR = {OP_JR,  27'($urandom)};
                5, 6:    IR = {OP_JAL, 27'($urandom)};
                7, 8:    IR = {OP_NOP, 27'($urandom)};
                9:       IR = {OP_HALT, 27'($urandom)};
                default: IR = $urandom;
            endcase
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_sequencer.md
# branch_sequencer

Parametrised micro-sequencer for the RISC datapath: a single FSM that drives the datapath control strobes for instruction fetch and for control-flow instructions. It covers conditional branch, jump-register, jump-and-link, nop and halt. It adds a memory-ready handshake with timeout, a registered branch decision, a retired-instruction counter and run/halt control. It sits beside the datapath, reads the instruction register and CON flip-flop outputs, and drives the datapath's one-bit control inputs.

## Interface
- DATA_W, 32, instruction register width
- OPCODE_W, 5, opcode field width; opcode = IR[DATA_W-1 -: OPCODE_W]
- BR_OP, 5'b10010, conditional branch opcode
- JR_OP, 5'b10100, jump-register opcode
- JAL_OP, 5'b10011, jump-and-link opcode
- NOP_OP, 5'b11010, no-operation opcode
- HALT_OP, 5'b11011, halt opcode
- TIMEOUT, 16, maximum wait cycles for Mem_ready in FETCH1
- COUNT_W, 16, retired-instruction counter width

Ports:
- Clock  in  1  system clock; all state changes on rising edge
- Reset  in  1  synchronous, active-low reset
- Run  in  1  level; allows sequencer to start/continue fetching
- IR  in  DATA_W  instruction register contents from datapath
- CON_FF  in  1  branch condition flip-flop output from datapath
- Mem_ready  in  1  memory read data valid
- PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin  out  1 each  fetch/PC strobes
- Gra, Grb, Rout, Rin, CONin, Yin, Cout, Zin, Zlowout  out  1 each  execute strobes
- Busy  out  1  high in every state except IDLE, HALT, ERROR
- Halted  out  1  high in HALT
- Mem_timeout  out  1  high in ERROR
- Illegal  out  1  sticky; set on an undefined opcode, cleared by reset
- Instr_count  out  COUNT_W  retired instructions, modulo 2^COUNT_W

## Operation
- States: IDLE, FETCH0, FETCH1, FETCH2, DECODE, BR3, BR4, BR5, BR6, JR3, JAL3, JAL4, HALT, ERROR.
- All strobes are Moore outputs decoded from the state register only. Every strobe not listed for a state is 0.
- IDLE: no strobes.
  - Run=1 -> FETCH0; otherwise stay.
- FETCH0: PCout, MARin, IncPC, PCin. -> FETCH1.
- FETCH1: Read, MDRin. Waits for memory.
  - Mem_ready=1 -> FETCH2.
  - Otherwise the wait counter increments.
  - Wait counter == TIMEOUT-1 with Mem_ready=0 -> ERROR.
  - Wait counter clears on entry to FETCH1.
- FETCH2: MDRout, IRin. -> DECODE.
- DECODE: no strobes. Dispatch on opcode:
  - BR_OP -> BR3
  - JR_OP -> JR3
  - JAL_OP -> JAL3
  - HALT_OP -> HALT
  - NOP_OP retires
  - any other opcode: set Illegal, retire as nop
- BR3: Gra, Rout, CONin. -> BR4.
- BR4: PCout, Yin. -> BR5.
- BR5: Cout, Zin. -> BR6. On this edge, CON_FF is captured into the internal register take_r.
- BR6: Zlowout and PCin only if take_r=1; no strobes if take_r=0. Retires.
- JR3: Gra, Rout, PCin. Retires.
- JAL3: PCout, Grb, Rin. -> JAL4.
- JAL4: Gra, Rout, PCin. Retires.
- Retire: Instr_count += 1 (wraps). Next state is FETCH0 if Run=1, else IDLE.
  - HALT_OP also increments Instr_count on entry to HALT.
- HALT and ERROR: terminal; no strobes. Only Reset exits.
- Reset (Reset=0 at a rising edge), in any state including mid-wait or mid-branch:
  - next state IDLE
  - all strobes 0, Busy=0, Halted=0, Mem_timeout=0, Illegal=0
  - Instr_count=0, take_r=0, wait counter=0

## Timing
- Zero-wait fetch: FETCH0 through DECODE take 4 cycles.
- Per-instruction cycle counts, Run held at 1, no wait states, IDLE -> FETCH0 edge excluded:
  - nop: 4
  - jr: 5
  - jal: 6
  - br: 8
- Each Mem_ready=0 cycle in FETCH1 adds exactly one cycle.
- ERROR is entered on the edge ending the TIMEOUT-th consecutive wait cycle.
- Branch decision uses CON_FF as sampled at the end of BR5, two cycles after CONin was asserted. A CON_FF change during BR6 has no effect.
- Run is sampled only in IDLE and on retire edges. Deasserting Run mid-instruction completes that instruction.
- Illegal rises one cycle after DECODE.

## Test plan
- Reset held low 2 cycles, then high, Run=0 -> all strobes 0, Busy=0, Instr_count=0, state stays IDLE for 5 cycles.
- Run=1, IR=BR_OP<<27, CON_FF=1 in BR5, Mem_ready=1 -> strobe sequence:
  - FETCH0, FETCH1, FETCH2, DECODE, BR3, BR4, BR5, BR6
  - Zlowout=PCin=1 in cycle 8
  - Instr_count=1
- Same branch with CON_FF=0 -> BR6 has no strobes, still 8 cycles, Instr_count=1.
- Mem_ready=0 for 3 cycles, then 1 -> FETCH1 lasts 4 cycles. With Mem_ready stuck 0 and TIMEOUT=16 -> Mem_timeout=1 after 16 FETCH1 cycles, Busy=0.
- Sequence JAL, JR, NOP, opcode 5'b11111, HALT_OP:
  - cycle counts 6, 5, 4, 4
  - Illegal=1 after the 5'b11111 decode
  - Halted=1, Instr_count=5
- Reset=0 asserted during BR4 -> next edge IDLE, all outputs 0, take_r=0, Instr_count=0.
